// File: rtl/charge_bay_if.sv
// Bus between the per-bay coin/mode logic and the shared-charger scheduler.
// The master side supplies enable, strobes and credits. The slave side (the
// scheduler) returns the charger state and the session-complete pulses.
interface charge_bay_if #(
    parameter int NUM_BAYS = 4,
    parameter int BAY_W    = 2,
    parameter int TIME_W   = 12
);
    logic                Enable;
    logic                Tick;
    logic                CreditValid;
    logic [BAY_W-1:0]    CreditBay;
    logic [TIME_W-1:0]   CreditMinutes;
    logic                Abort;
    logic                ChargerOn;
    logic [BAY_W-1:0]    ActiveBay;
    logic [TIME_W-1:0]   RemainingTime;
    logic [NUM_BAYS-1:0] BayDone;
    logic                Busy;

    modport master (
        output Enable, Tick, CreditValid, CreditBay, CreditMinutes, Abort,
        input  ChargerOn, ActiveBay, RemainingTime, BayDone, Busy
    );

    modport slave (
        input  Enable, Tick, CreditValid, CreditBay, CreditMinutes, Abort,
        output ChargerOn, ActiveBay, RemainingTime, BayDone, Busy
    );
endinterface

// File: rtl/charge_bay_scheduler.sv
// Round-robin time-sharing of one charger among NUM_BAYS bays. Each bay
// banks purchased minutes in a pending register; the granted bay's minutes
// are moved into RemainingTime and counted down on the one-minute strobe.
module charge_bay_scheduler #(
    parameter int NUM_BAYS = 4,
    parameter int BAY_W    = 2,
    parameter int TIME_W   = 12
) (
    input  logic         Clk,
    input  logic         nReset,
    charge_bay_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHARGE, S_DONE} state_t;

    localparam logic [BAY_W:0]   NUM_BAYS_L = (BAY_W+1)'(NUM_BAYS);
    localparam logic [BAY_W-1:0] LAST_INIT  = BAY_W'(NUM_BAYS - 1);

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   pend_q [NUM_BAYS];
    logic [TIME_W-1:0]   pend_d [NUM_BAYS];
    logic [TIME_W-1:0]   rem_q, rem_d;
    logic [BAY_W-1:0]    active_bay_q, active_bay_d;
    logic [BAY_W-1:0]    last_bay_q, last_bay_d;
    logic                credit_ok;
    logic                topup;
    logic                grant_found;
    logic [BAY_W-1:0]    grant_bay;

    // Saturating add: minute counters pin at all-ones instead of wrapping.
    function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] a,
                                                  input logic [TIME_W-1:0] b);
        logic [TIME_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TIME_W] ? '1 : s[TIME_W-1:0];
    endfunction

    // Credits to a non-existent bay are dropped; credits to the bay that is
    // loading or charging go straight into its running countdown.
    assign credit_ok = bus.CreditValid && ({1'b0, bus.CreditBay} < NUM_BAYS_L);
    assign topup     = credit_ok && (bus.CreditBay == active_bay_q) &&
                       (state_q == S_LOAD || state_q == S_CHARGE);

    // Round-robin pick: first bay with credit after the last-served bay.
    always_comb begin
        int               idx;
        logic [BAY_W-1:0] idx_b;
        grant_found = 1'b0;
        grant_bay   = '0;
        idx         = 0;
        idx_b       = '0;
        for (int i = 1; i <= NUM_BAYS; i++) begin
            idx   = (int'(last_bay_q) + i) % NUM_BAYS;
            idx_b = BAY_W'(idx);
            if (!grant_found && pend_q[idx_b] != '0) begin
                grant_found = 1'b1;
                grant_bay   = idx_b;
            end
        end
    end

    // Datapath next-state: pending credits, countdown, grant bookkeeping.
    always_comb begin
        pend_d       = pend_q;
        rem_d        = rem_q;
        active_bay_d = active_bay_q;
        last_bay_d   = last_bay_q;
        if (credit_ok && !topup) begin
            pend_d[bus.CreditBay] = sat_add(pend_q[bus.CreditBay], bus.CreditMinutes);
        end
        case (state_q)
            S_IDLE: begin
                if (bus.Enable && grant_found) begin
                    active_bay_d = grant_bay;
                end
            end
            S_LOAD: begin
                rem_d                = sat_add(pend_q[active_bay_q],
                                               topup ? bus.CreditMinutes : '0);
                pend_d[active_bay_q] = '0;
            end
            S_CHARGE: begin
                if (bus.Abort) begin
                    rem_d = '0;
                end else begin
                    rem_d = rem_q - TIME_W'(bus.Enable && bus.Tick);
                    if (topup) begin
                        rem_d = sat_add(rem_d, bus.CreditMinutes);
                    end
                end
            end
            S_DONE: begin
                last_bay_d = active_bay_q;
            end
            default: ;
        endcase
    end

    // FSM next state; a session ends when the countdown lands on zero.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.Enable && grant_found) state_d = S_LOAD;
            S_LOAD:   state_d = S_CHARGE;
            S_CHARGE: if (bus.Abort || rem_d == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; charger power also follows Enable.
    always_comb begin
        bus.ChargerOn     = (state_q == S_CHARGE) && bus.Enable;
        bus.Busy          = (state_q != S_IDLE);
        bus.ActiveBay     = active_bay_q;
        bus.RemainingTime = rem_q;
        bus.BayDone       = '0;
        if (state_q == S_DONE) begin
            bus.BayDone[active_bay_q] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset discards every banked credit.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int b = 0; b < NUM_BAYS; b++) begin
                pend_q[b] <= '0;
            end
            rem_q        <= '0;
            active_bay_q <= '0;
            last_bay_q   <= LAST_INIT;
        end else begin
            pend_q       <= pend_d;
            rem_q        <= rem_d;
            active_bay_q <= active_bay_d;
            last_bay_q   <= last_bay_d;
        end
    end
endmodule

// File: doc/charge_bay_scheduler.md
Name: charge_bay_scheduler

Overview:
Time-shares one charging output and its minute countdown among NUM_BAYS charging bays.
Each bay accumulates purchased minutes in its own pending register. The scheduler grants the charger to one bay at a time, in round-robin order, and counts that bay's minutes down on an external one-minute strobe.
It sits between the per-bay coin/mode logic, which supplies the credits, and the charger power switch and display.

Parameters:
NUM_BAYS, 4, number of bays sharing the charger (2..8)
BAY_W, 2, width of bay index (ceil(log2(NUM_BAYS)), minimum 1)
TIME_W, 12, width of minute counters; all sums saturate at 2^TIME_W-1

Ports:
Clk  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
Enable  in  1  station enable; low pauses charging and blocks new grants
Tick  in  1  one-cycle one-minute strobe
CreditValid  in  1  credit write strobe
CreditBay  in  BAY_W  bay index for the credit
CreditMinutes  in  TIME_W  minutes to add
Abort  in  1  one-cycle strobe; terminates the active session
ChargerOn  out  1  charger power enable
ActiveBay  out  BAY_W  bay currently granted
RemainingTime  out  TIME_W  minutes left for ActiveBay
BayDone  out  NUM_BAYS  one-hot, one-cycle session-complete pulse
Busy  out  1  high in LOAD, CHARGE and DONE

Behaviour:
- Reset (async, nReset=0):
  - state=IDLE; all outputs 0.
  - All PendCredit[b]=0; LastBay=NUM_BAYS-1, so the first grant scan starts at bay 0.
- Credit handling, every cycle:
  - If CreditValid and CreditBay>=NUM_BAYS: the credit is ignored.
  - If CreditValid and CreditBay==ActiveBay and state is LOAD or CHARGE: RemainingTime <= sat(RemainingTime + CreditMinutes). This is a top-up; PendCredit is untouched.
  - Otherwise: PendCredit[CreditBay] <= sat(PendCredit[CreditBay] + CreditMinutes).
  - CreditMinutes=0 is legal and has no effect.
- IDLE:
  - ChargerOn=0.
  - If Enable=1 and any PendCredit is nonzero: choose the first bay with nonzero credit, scanning LastBay+1, LastBay+2, ... modulo NUM_BAYS. Then ActiveBay<=sel, go to LOAD.
  - The credit to the selected bay arriving in this same cycle lands in PendCredit and is consumed by LOAD.
- LOAD (one cycle):
  - RemainingTime <= PendCredit[ActiveBay], plus any same-cycle CreditValid to ActiveBay (saturated).
  - PendCredit[ActiveBay] <= 0.
  - Go to CHARGE.
- CHARGE:
  - ChargerOn = Enable.
  - If Enable=1 and Tick=1: RemainingTime decrements.
  - Transition to DONE when RemainingTime reaches 0, i.e. on a Tick with RemainingTime==1, unless a same-cycle top-up is added.
  - If Tick and a top-up to ActiveBay occur in the same cycle: RemainingTime <= sat(RemainingTime - 1 + CreditMinutes).
  - If Enable=0: Tick is ignored, state is held, RemainingTime is held.
  - Abort=1, which has priority over Tick and top-up: RemainingTime<=0, go to DONE.
- DONE (one cycle):
  - ChargerOn=0; BayDone[ActiveBay]=1; LastBay<=ActiveBay; go to IDLE.
  - ActiveBay holds its value in IDLE until the next grant.
- Latency:
  - Credit at edge k into an empty IDLE scheduler: LOAD after edge k+1, CHARGE after edge k+2.
  - ChargerOn rises after edge k+2; RemainingTime is valid at the same time.
- Fairness: a bay granted last is scanned last. No bay waits more than NUM_BAYS-1 sessions.
- Mid-operation reset: immediate return to the reset state; all pending credits are lost.
- Abort outside CHARGE is ignored. Tick outside CHARGE is ignored.

Test Plan:
- Reset, then CreditValid bay1 = 3 -> LOAD 1 cycle later, CHARGE next cycle, ChargerOn=1, RemainingTime=3. After 3 Ticks: BayDone=4'b0010 for one cycle, ChargerOn=0.
- Credits 2 to bays 0, 2, 3 in one IDLE period -> grants in order 0, 2, 3. Then credit 1 to bay 0 during bay 3's session -> bay 0 is granted next; BayDone pulses in order 0, 2, 3, 0.
- During CHARGE on bay 2 with RemainingTime=5: top-up 4 coincident with Tick -> RemainingTime=8; credit 6 to bay 1 -> PendCredit[1]=6, no change to RemainingTime.
- Enable=0 for 10 Ticks mid-session with RemainingTime=4 -> ChargerOn=0, RemainingTime stays 4. Enable=1 -> counting resumes.
- PendCredit=4090 plus credit 100 -> saturates at 4095. Abort at RemainingTime=7 -> DONE next cycle, BayDone pulse, RemainingTime=0. CreditBay=3 with NUM_BAYS=3 -> ignored.
- nReset low during CHARGE -> ChargerOn, Busy, RemainingTime=0 immediately, asynchronously. After release no grant occurs, because all credits were cleared.
